csa_accum_seq: RTL

CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

---
 rtl/csa_pkg.sv | 25 ++
 rtl/compressor32.sv | 27 ++
 rtl/csa_accum_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
//   Shared definitions for the carry-save accumulator:
//     - csa_state_t : FSM state encoding (IDLE, ACCUM, RESOLVE, OUT)
//     - csa_aw()    : accumulator width derivation, AW = NN + GW
//     - default operand width and guard-bit count
// -----------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_NN_DEFAULT = 16;
    localparam int CSA_GW_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_OUT     = 2'd3
    } csa_state_t;

    // Accumulator width: operand width plus guard bits.
    function automatic int csa_aw(input int nn, input int gw);
        return nn + gw;
    endfunction

endpackage

// File: rtl/compressor32.sv
// -----------------------------------------------------------------------------
// compressor32
//   Bit-parallel 3:2 carry-save compressor of width W.
//   Ports:
//     a, b, c : W-bit addends
//     sum     : a ^ b ^ c
//     carry   : majority(a, b, c) shifted left by one, truncated to W bits
//   a + b + c == sum + carry (mod 2^W), plus the majority MSB that the shift
//   drops; the caller recovers that bit itself if it cares about overflow.
// -----------------------------------------------------------------------------
module compressor32 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/csa_accum_seq.sv
// -----------------------------------------------------------------------------
// csa_accum_seq
//   Sequential carry-save accumulator. Operands of a group are folded into a
//   redundant (sum, carry) pair with one 3:2 compression per accepted operand;
//   after the last operand a single RESOLVE cycle does the one carry-propagate
//   add, and the result is offered on a valid/ready output.
//
//   Parameters:
//     NN : operand width (unsigned)
//     GW : guard bits; accumulator width AW = NN + GW
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : operand presented
//     in_ready  : operand accepted this cycle (high in IDLE / ACCUM)
//     in_data   : operand, zero-extended to AW
//     in_last   : final operand of the group, sampled with in_data
//     out_valid : result available (OUT state)
//     out_ready : consumer takes the result
//     out_data  : group sum modulo 2^AW, held stable while out_valid
//     out_ovf   : (only with CSA_ACCUM_OVF_EN) sticky overflow of the group,
//                 valid with out_valid
//
//   Build option:
//     CSA_ACCUM_OVF_EN : adds out_ovf and its tracking logic. Without it the
//                        sum wraps silently modulo 2^AW.
//
//   Timing: last operand accepted at edge t -> RESOLVE during the following
//   cycle -> out_valid high after edge t+1, so the earliest output handshake
//   is at edge t+2. Only one group is ever in flight.
// -----------------------------------------------------------------------------
module csa_accum_seq
    import csa_pkg::*;
#(
    parameter int  NN = CSA_NN_DEFAULT,
    parameter int  GW = CSA_GW_DEFAULT,
    localparam int AW = csa_aw(NN, GW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NN-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef CSA_ACCUM_OVF_EN
    output logic          out_ovf,
`endif
    output logic [AW-1:0] out_data
);

    csa_state_t state;
    csa_state_t state_nxt;

    logic          accept;
    logic [AW-1:0] x_ext;
    logic [AW-1:0] sum_q;
    logic [AW-1:0] carry_q;
    logic [AW-1:0] csa_sum;
    logic [AW-1:0] csa_carry;
    logic [AW-1:0] res_sum;

    assign x_ext = AW'(in_data);

    // One 3:2 step per accepted operand; the carry output is already shifted.
    compressor32 #(
        .W (AW)
    ) u_csa (
        .a     (sum_q),
        .b     (carry_q),
        .c     (x_ext),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

`ifdef CSA_ACCUM_OVF_EN
    logic ovf_q;
    logic carry_drop;
    logic res_cout;

    // Majority of the MSBs is the carry bit that the shift pushes out of AW.
    assign carry_drop = (sum_q[AW-1] & carry_q[AW-1])
                      | (sum_q[AW-1] & x_ext[AW-1])
                      | (carry_q[AW-1] & x_ext[AW-1]);

    assign {res_cout, res_sum} = {1'b0, sum_q} + {1'b0, carry_q};
    assign out_ovf = ovf_q;
`else
    assign res_sum = sum_q + carry_q;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next state and handshake outputs ----
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---- accumulator datapath ----
    // The first operand of a group loads sum directly and clears carry, so no
    // explicit clear is needed between groups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            carry_q  <= '0;
            out_data <= '0;
`ifdef CSA_ACCUM_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sum_q   <= x_ext;
                        carry_q <= '0;
`ifdef CSA_ACCUM_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        sum_q   <= csa_sum;
                        carry_q <= csa_carry;
`ifdef CSA_ACCUM_OVF_EN
                        ovf_q   <= ovf_q | carry_drop;
`endif
                    end
                end
                ST_RESOLVE: begin
                    out_data <= res_sum;
`ifdef CSA_ACCUM_OVF_EN
                    ovf_q    <= ovf_q | res_cout;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule
